// File: rtl/mem_access_stage_if.sv
// Bundled EX-input, data-bus and write-back signals of the MEM stage.
// The master modport is the stage itself; slave is the surrounding pipeline and memory.
interface mem_access_stage_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned REG_W = 5
);
    logic             ex_valid;
    logic             ex_ready;
    logic [W-1:0]     ex_result;
    logic [W-1:0]     ex_rt_val;
    logic [3:0]       ex_mem_op;
    logic [REG_W-1:0] ex_wb_reg;

    logic             dbus_req;
    logic             dbus_we;
    logic [W-1:0]     dbus_addr;
    logic [3:0]       dbus_be;
    logic [W-1:0]     dbus_wdata;
    logic             dbus_ack;
    logic [W-1:0]     dbus_rdata;

    logic             wb_valid;
    logic             wb_we;
    logic [REG_W-1:0] wb_reg;
    logic [W-1:0]     wb_data;
    logic             addr_err_load;
    logic             addr_err_store;
    logic [W-1:0]     badvaddr;

    modport master (
        input  ex_valid, ex_result, ex_rt_val, ex_mem_op, ex_wb_reg, dbus_ack, dbus_rdata,
        output ex_ready, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
               wb_valid, wb_we, wb_reg, wb_data, addr_err_load, addr_err_store, badvaddr
    );

    modport slave (
        output ex_valid, ex_result, ex_rt_val, ex_mem_op, ex_wb_reg, dbus_ack, dbus_rdata,
        input  ex_ready, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
               wb_valid, wb_we, wb_reg, wb_data, addr_err_load, addr_err_store, badvaddr
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: single-outstanding load/store bus access, load alignment/extension,
// misalignment detection, one write-back record per accepted op.
module mem_access_stage #(
    parameter int unsigned W     = 32,
    parameter int unsigned REG_W = 5
) (
    input logic                clk,
    input logic                rst,
    mem_access_stage_if.master bus
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic {S_IDLE, S_BUS} state_e;

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [W-1:0]     addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [W-1:0]     wdata_q, wdata_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       lane_q, lane_d;
    logic [REG_W-1:0] reg_q, reg_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_we_q, wb_we_d;
    logic [REG_W-1:0] wb_reg_q, wb_reg_d;
    logic [W-1:0]     wb_data_q, wb_data_d;
    logic             err_ld_q, err_ld_d;
    logic             err_st_q, err_st_d;
    logic [W-1:0]     badvaddr_q, badvaddr_d;

    logic             is_load, is_store, misaligned;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [W-1:0]     load_val;

    // Decode of the op currently offered by EX
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (bus.ex_mem_op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load  = 1'b1; misaligned = bus.ex_result[0];    end
            OP_LW:         begin is_load  = 1'b1; misaligned = |bus.ex_result[1:0]; end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; misaligned = bus.ex_result[0];    end
            OP_SW:         begin is_store = 1'b1; misaligned = |bus.ex_result[1:0]; end
            default: ;
        endcase
    end

    // Lane extraction uses the address latched at accept, not the live EX input
    always_comb begin
        rd_byte  = bus.dbus_rdata[8*lane_q +: 8];
        rd_half  = bus.dbus_rdata[16*lane_q[1] +: 16];
        load_val = bus.dbus_rdata;
        case (op_q)
            OP_LB:   load_val = {{(W-8){rd_byte[7]}}, rd_byte};
            OP_LBU:  load_val = {{(W-8){1'b0}}, rd_byte};
            OP_LH:   load_val = {{(W-16){rd_half[15]}}, rd_half};
            OP_LHU:  load_val = {{(W-16){1'b0}}, rd_half};
            default: load_val = bus.dbus_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        lane_d     = lane_q;
        reg_d      = reg_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = '0;
        err_ld_d   = 1'b0;
        err_st_d   = 1'b0;
        badvaddr_d = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid) begin
                    if (!is_load && !is_store) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b1;
                        wb_reg_d   = bus.ex_wb_reg;
                        wb_data_d  = bus.ex_result;
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_reg_d   = bus.ex_wb_reg;
                        err_ld_d   = is_load;
                        err_st_d   = is_store;
                        badvaddr_d = bus.ex_result;
                    end else begin
                        state_d = S_BUS;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {bus.ex_result[W-1:2], 2'b00};
                        op_d    = bus.ex_mem_op;
                        lane_d  = bus.ex_result[1:0];
                        reg_d   = bus.ex_wb_reg;
                        be_d    = 4'b1111;
                        wdata_d = bus.ex_rt_val;
                        if (bus.ex_mem_op == OP_SB) begin
                            be_d    = 4'b0001 << bus.ex_result[1:0];
                            wdata_d = {(W/8){bus.ex_rt_val[7:0]}};
                        end else if (bus.ex_mem_op == OP_SH) begin
                            be_d    = bus.ex_result[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {(W/16){bus.ex_rt_val[15:0]}};
                        end
                    end
                end
            end
            S_BUS: begin
                if (bus.dbus_ack) begin
                    state_d    = S_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = !we_q;
                    wb_reg_d   = reg_q;
                    wb_data_d  = we_q ? '0 : load_val;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            op_q       <= '0;
            lane_q     <= '0;
            reg_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            err_ld_q   <= 1'b0;
            err_st_q   <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            reg_q      <= reg_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            err_ld_q   <= err_ld_d;
            err_st_q   <= err_st_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign bus.ex_ready       = (state_q == S_IDLE);
    assign bus.dbus_req       = req_q;
    assign bus.dbus_we        = we_q;
    assign bus.dbus_addr      = addr_q;
    assign bus.dbus_be        = be_q;
    assign bus.dbus_wdata     = wdata_q;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_we          = wb_we_q;
    assign bus.wb_reg         = wb_reg_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.addr_err_load  = err_ld_q;
    assign bus.addr_err_store = err_st_q;
    assign bus.badvaddr       = badvaddr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected write-back records are queued at issue
// and compared as the stage emits them; bus-side signals are checked at each step.
module tb_mem_access_stage;
    typedef struct packed {
        logic        we;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        el;
        logic        es;
        logic [31:0] bad;
    } rec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    rec_t sb[$];

    mem_access_stage_if #(.W(32), .REG_W(5)) bus ();

    mem_access_stage #(.W(32), .REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample just after the edge and retire any write-back record
    task automatic step();
        rec_t r;
        @(posedge clk);
        #1;
        if (bus.wb_valid === 1'b1) begin
            chk("wb_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                chk("wb_we",       32'(bus.wb_we),          32'(r.we));
                chk("wb_reg",      32'(bus.wb_reg),         32'(r.rg));
                chk("wb_data",     bus.wb_data,             r.data);
                chk("err_load",    32'(bus.addr_err_load),  32'(r.el));
                chk("err_store",   32'(bus.addr_err_store), 32'(r.es));
                chk("badvaddr",    bus.badvaddr,            r.bad);
            end
        end else begin
            chk("idle_err_load",  32'(bus.addr_err_load),  32'd0);
            chk("idle_err_store", 32'(bus.addr_err_store), 32'd0);
            chk("idle_badvaddr",  bus.badvaddr,            32'd0);
        end
    endtask

    function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
        logic [3:0] be;
        be = 4'b1111;
        if (op == 4'd8) begin
            case (a[1:0])
                2'd0: be = 4'b0001;
                2'd1: be = 4'b0010;
                2'd2: be = 4'b0100;
                default: be = 4'b1000;
            endcase
        end else if (op == 4'd9) begin
            be = (a[1:0] == 2'd2) ? 4'b1100 : 4'b0011;
        end
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] rt);
        if (op == 4'd8) return 32'(rt[7:0]) * 32'h0101_0101;
        if (op == 4'd9) return 32'(rt[15:0]) * 32'h0001_0001;
        return rt;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
        h = (rd >> (16 * a[1])) & 32'h0000_FFFF;
        case (op)
            4'd1: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            4'd2: return b;
            4'd3: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            4'd4: return h;
            default: return rd;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input logic [4:0] rg);
        bus.ex_valid  = 1'b1;
        bus.ex_mem_op = op;
        bus.ex_result = a;
        bus.ex_rt_val = rt;
        bus.ex_wb_reg = rg;
    endtask

    task automatic release_ex();
        bus.ex_valid  = 1'b0;
        bus.ex_mem_op = 4'd0;
    endtask

    task automatic do_none(input logic [31:0] v, input logic [4:0] rg);
        drive(4'd0, v, 32'h0, rg);
        sb.push_back('{we: 1'b1, rg: rg, data: v, el: 1'b0, es: 1'b0, bad: 32'h0});
        step();
        release_ex();
        chk("none_wb_valid", 32'(bus.wb_valid), 32'd1);
    endtask

    task automatic do_mem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                          input logic [31:0] rd, input logic [4:0] rg, input int waits);
        logic st;
        st = (op >= 4'd8);
        drive(op, a, rt, rg);
        chk("ready_idle", 32'(bus.ex_ready), 32'd1);
        sb.push_back('{we: !st, rg: rg, data: st ? 32'h0 : exp_load(op, a, rd),
                       el: 1'b0, es: 1'b0, bad: 32'h0});
        step();
        release_ex();
        chk("bus_req",   32'(bus.dbus_req),  32'd1);
        chk("bus_we",    32'(bus.dbus_we),   32'(st));
        chk("bus_addr",  bus.dbus_addr,      a & 32'hFFFF_FFFC);
        chk("bus_be",    32'(bus.dbus_be),   32'(exp_be(op, a)));
        if (st) chk("bus_wdata", bus.dbus_wdata, exp_wdata(op, rt));
        chk("ready_bus", 32'(bus.ex_ready),  32'd0);
        for (int i = 0; i < waits; i++) begin
            step();
            chk("bus_req_held",  32'(bus.dbus_req), 32'd1);
            chk("bus_addr_held", bus.dbus_addr,     a & 32'hFFFF_FFFC);
            chk("ready_wait",    32'(bus.ex_ready), 32'd0);
            chk("no_early_wb",   32'(bus.wb_valid), 32'd0);
        end
        bus.dbus_ack   = 1'b1;
        bus.dbus_rdata = rd;
        step();
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = 32'h0;
        chk("req_dropped",  32'(bus.dbus_req), 32'd0);
        chk("mem_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("ready_after",  32'(bus.ex_ready), 32'd1);
    endtask

    task automatic do_misaligned(input logic [3:0] op, input logic [31:0] a, input logic [4:0] rg);
        logic st;
        st = (op >= 4'd8);
        drive(op, a, 32'h5555_AAAA, rg);
        sb.push_back('{we: 1'b0, rg: rg, data: 32'h0, el: !st, es: st, bad: a});
        step();
        release_ex();
        chk("mis_no_req",   32'(bus.dbus_req), 32'd0);
        chk("mis_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("mis_ready",    32'(bus.ex_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.ex_valid   = 1'b0;
        bus.ex_mem_op  = 4'd0;
        bus.ex_result  = 32'h0;
        bus.ex_rt_val  = 32'h0;
        bus.ex_wb_reg  = 5'd0;
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = 32'h0;

        step();
        step();
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_req",      32'(bus.dbus_req), 32'd0);
        chk("rst_ready",    32'(bus.ex_ready), 32'd1);
        chk("rst_wb_data",  bus.wb_data,       32'd0);
        chk("rst_be",       32'(bus.dbus_be),  32'd0);
        rst = 1'b0;
        step();

        do_none(32'h1234_5678, 5'd3);
        step();
        chk("none_single_pulse", 32'(bus.wb_valid), 32'd0);

        do_mem(4'd8,  32'h0000_1003, 32'hAABB_CCDD, 32'h0,          5'd7,  3);
        do_mem(4'd1,  32'h0000_2002, 32'h0,          32'h0080_0000, 5'd8,  0);
        do_mem(4'd2,  32'h0000_2002, 32'h0,          32'h0080_0000, 5'd9,  1);
        do_mem(4'd3,  32'h0000_2002, 32'h0,          32'h8001_0000, 5'd10, 2);
        do_mem(4'd4,  32'h0000_2000, 32'h0,          32'h1234_F00D, 5'd11, 0);
        do_mem(4'd5,  32'h0000_2000, 32'h0,          32'hCAFE_BABE, 5'd12, 1);
        do_mem(4'd9,  32'h0000_2006, 32'h1111_BEEF, 32'h0,          5'd13, 0);
        do_mem(4'd10, 32'h0000_2008, 32'hDEAD_BEEF, 32'h0,          5'd14, 2);
        do_mem(4'd8,  32'h0000_2004, 32'h0000_0042, 32'h0,          5'd15, 0);

        do_misaligned(4'd5, 32'h0000_3002, 5'd16);
        do_misaligned(4'd9, 32'h0000_3001, 5'd17);
        do_misaligned(4'd3, 32'h0000_3003, 5'd18);
        step();

        do_none(32'h0000_0001, 5'd1);
        do_none(32'h0000_0002, 5'd2);
        do_none(32'h0000_0003, 5'd4);
        do_none(32'hFFFF_FFFF, 5'd31);
        step();

        // Reset in the middle of a bus request drops the op entirely
        drive(4'd5, 32'h0000_4000, 32'h0, 5'd20);
        step();
        release_ex();
        chk("rb_req", 32'(bus.dbus_req), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rb_req_cleared", 32'(bus.dbus_req), 32'd0);
        chk("rb_no_wb",       32'(bus.wb_valid), 32'd0);
        chk("rb_ready",       32'(bus.ex_ready), 32'd1);
        rst = 1'b0;
        bus.dbus_ack   = 1'b1;
        bus.dbus_rdata = 32'h7777_7777;
        step();
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = 32'h0;
        chk("stray_ack_no_wb",  32'(bus.wb_valid), 32'd0);
        chk("stray_ack_no_req", 32'(bus.dbus_req), 32'd0);
        step();
        chk("stray_ack_late_wb", 32'(bus.wb_valid), 32'd0);
        do_none(32'h0BAD_F00D, 5'd21);
        do_mem(4'd5, 32'h0000_5000, 32'h0, 32'h0102_0304, 5'd22, 1);
        step();
        step();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
